alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Initiator-side controller for the team's combinational ALU. It accepts instructions over a valid/ready channel and reads operands from an internal register file. It drives the ALU operand and opcode ports, captures the result and flags, writes the result back, and returns a response over a second valid/ready channel. It sits between the instruction source and the ALU and owns all sequencing the ALU lacks.

Parameters:
BW, 16, datapath bitwidth; matches the ALU operand width.
NREG, 8, number of general registers.
AW, $clog2(NREG), register index width (derived, not overridable).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept an instruction
instr_op  in  3  ALU opcode, passed through unchanged
instr_ra  in  AW  source register A index
instr_rb  in  AW  source register B index
instr_rd  in  AW  destination register index
wr_en  in  1  external register write strobe
wr_addr  in  AW  external write index
wr_data  in  BW  external write data
alu_a  out  BW  ALU operand A
alu_b  out  BW  ALU operand B
alu_op  out  3  ALU opcode
alu_out  in  BW+1  ALU result (signed)
alu_flags  in  3  ALU flags {overflow, negative, zero}
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_data  out  BW+1  full-width ALU result
rsp_flags  out  3  captured flags
rsp_rd  out  AW  destination index of this result
status_flags  out  3  flags of last completed instruction (sticky until next)

Behaviour:
- Reset is synchronous on clk while rst_n=0 and overrides everything.
- Reset values:
  - state=IDLE.
  - Register file all 0.
  - instr_ready=0 while rst_n=0, 1 in the first cycle after release.
  - rsp_valid=0.
  - rsp_data=0, rsp_flags=0, rsp_rd=0, status_flags=0.
  - alu_a=0, alu_b=0, alu_op=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, register op, rf[ra], rf[rb] and rd into operand registers, then go to EXEC.
  - Operands read the pre-edge register contents. There is no bypass from a same-cycle wr_en to the same index.
- EXEC:
  - instr_ready=0.
  - alu_a, alu_b and alu_op are driven from the operand registers only, stable for the whole cycle.
  - At the end of the cycle: capture alu_out→rsp_data, alu_flags→rsp_flags and status_flags, rd→rsp_rd.
  - Write rf[rd] <= alu_out[BW-1:0]; bit BW is not stored.
  - Go to RESP.
- RESP:
  - rsp_valid=1, and rsp_data, rsp_flags and rsp_rd are held stable until the handshake.
  - On rsp_valid&rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Instruction accepted at edge N.
  - rsp_valid high in cycle N+2.
  - Best-case throughput is one instruction per 3 cycles, with rsp_ready held high.
- Outside EXEC, alu_a, alu_b and alu_op hold their last values; the ALU output is ignored.
- External write:
  - wr_en writes rf[wr_addr] in any state.
  - If EXEC writeback targets the same index in the same cycle, the writeback wins and the external write is dropped.
  - Writes to different indices both take effect.
- ra==rb and rd==ra/rb are legal. rd is updated only after the operands were sampled.
- Opcodes 110 and 111 are moves: rd gets operand A or operand B, with flags captured as reported by the ALU.
- instr_* are ignored while instr_ready=0. Inputs must not be sampled in EXEC or RESP.
- Reset mid-operation (EXEC or RESP): the instruction is abandoned.
  - No writeback if reset is asserted in the EXEC cycle.
  - rsp_valid=0.
  - Register file cleared.
- rsp_ready high while rsp_valid=0 has no effect.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles → all outputs 0, instr_ready=0. Release → instr_ready=1 next cycle.
- Add, with the bench connecting the team's ALU (BW=16): wr r1=5 and r2=7; issue op=000 ra=1 rb=2 rd=3 → rsp_valid at N+2, rsp_data=12, rsp_flags=000, rsp_rd=3. A later move (op=110 ra=3) returns 12.
- Zero and overflow:
  - r1=r2=0x0042, op=001 → rsp_data=0, flags[0]=1.
  - r1=0x7FFF, r2=0x0001, op=000 → flags[2]=1, status_flags matches rsp_flags.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, instr_ready=0, new instr_valid ignored. rsp_ready=1 → IDLE next cycle, then the next instruction is accepted.
- Write collision: in the EXEC cycle writing rd=4, also assert wr_en wr_addr=4 wr_data=0xBEEF → rf[4] holds the ALU result. Repeat with wr_addr=5 → rf[5]=0xBEEF.
- Reset mid-op: assert rst_n=0 during EXEC → no response, rf[rd]=0, instr_ready=1 one cycle after release.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the channels around alu_issue_ctrl: instruction issue, external register
// write, ALU drive/return, and the response channel.
interface alu_issue_ctrl_if #(
   parameter int BW = 16,
   parameter int AW = 3
);
   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    instr_op;
   logic [AW-1:0] instr_ra;
   logic [AW-1:0] instr_rb;
   logic [AW-1:0] instr_rd;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [BW-1:0] wr_data;
   logic [BW-1:0] alu_a;
   logic [BW-1:0] alu_b;
   logic [2:0]    alu_op;
   logic [BW:0]   alu_out;
   logic [2:0]    alu_flags;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [BW:0]   rsp_data;
   logic [2:0]    rsp_flags;
   logic [AW-1:0] rsp_rd;
   logic [2:0]    status_flags;

   modport master (
      input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
      input  wr_en, wr_addr, wr_data,
      input  alu_out, alu_flags, rsp_ready,
      output instr_ready, alu_a, alu_b, alu_op,
      output rsp_valid, rsp_data, rsp_flags, rsp_rd, status_flags
   );

   modport slave (
      output instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
      output wr_en, wr_addr, wr_data,
      output alu_out, alu_flags, rsp_ready,
      input  instr_ready, alu_a, alu_b, alu_op,
      input  rsp_valid, rsp_data, rsp_flags, rsp_rd, status_flags
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: reads operands from a local register file,
// holds them on the ALU for one cycle, writes the result back and returns a response.
module alu_issue_ctrl #(
   parameter int BW   = 16,
   parameter int NREG = 8
) (
   input logic             clk,
   input logic             rst_n,
   alu_issue_ctrl_if.master bus
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [BW-1:0] r_rf [NREG];
   logic [2:0]    r_op;
   logic [BW-1:0] r_a;
   logic [BW-1:0] r_b;
   logic [AW-1:0] r_rd;
   logic          r_instr_ready;
   logic          r_rsp_valid;
   logic [BW:0]   r_rsp_data;
   logic [2:0]    r_rsp_flags;
   logic [AW-1:0] r_rsp_rd;
   logic [2:0]    r_status_flags;
   logic          w_accept;
   logic          w_exec;
   logic          w_rsp_done;

   assign w_accept   = (r_state == IDLE) && r_instr_ready && bus.instr_valid;
   assign w_exec     = (r_state == EXEC);
   assign w_rsp_done = (r_state == RESP) && r_rsp_valid && bus.rsp_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next_state = EXEC;
            else          w_next_state = IDLE;
         end
         EXEC:    w_next_state = RESP;
         RESP: begin
            if (w_rsp_done) w_next_state = IDLE;
            else            w_next_state = RESP;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Handshake outputs registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr_ready <= 1'b0;
         r_rsp_valid   <= 1'b0;
      end else begin
         r_instr_ready <= (w_next_state == IDLE);
         r_rsp_valid   <= (w_next_state == RESP);
      end
   end

   // Operand capture; these registers drive the ALU directly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op <= 3'b000;
         r_a  <= {BW{1'b0}};
         r_b  <= {BW{1'b0}};
         r_rd <= {AW{1'b0}};
      end else if (w_accept) begin
         r_op <= bus.instr_op;
         r_a  <= r_rf[bus.instr_ra];
         r_b  <= r_rf[bus.instr_rb];
         r_rd <= bus.instr_rd;
      end
   end

   // Result capture at the end of the execute cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_data     <= {(BW+1){1'b0}};
         r_rsp_flags    <= 3'b000;
         r_rsp_rd       <= {AW{1'b0}};
         r_status_flags <= 3'b000;
      end else if (w_exec) begin
         r_rsp_data     <= bus.alu_out;
         r_rsp_flags    <= bus.alu_flags;
         r_rsp_rd       <= r_rd;
         r_status_flags <= bus.alu_flags;
      end
   end

   // Register file: writeback beats an external write to the same index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= {BW{1'b0}};
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_exec && (r_rd == AW'(i))) begin
               r_rf[i] <= bus.alu_out[BW-1:0];
            end else if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
               r_rf[i] <= bus.wr_data;
            end
         end
      end
   end

   assign bus.instr_ready  = r_instr_ready;
   assign bus.alu_a        = r_a;
   assign bus.alu_b        = r_b;
   assign bus.alu_op       = r_op;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_data     = r_rsp_data;
   assign bus.rsp_flags    = r_rsp_flags;
   assign bus.rsp_rd       = r_rsp_rd;
   assign bus.status_flags = r_status_flags;
endmodule
